rc4_ksa_swap: RTL and testbench

- Key-scheduling stage (loop 2) of the RC4 decrypt datapath.
- Starts once the S-memory init loop (loop 1) has written S[i]=i for all 256 entries.
- Runs the KSA swap pass over the 256x8 S-memory: j = j + S[i] + key[i mod 3], then swaps S[i] and S[j].
- Drives the loop-2 address/data/wren inputs of the S-memory arbiter; its done output is the arbiter's loop_2_done and the start for the decrypt loop (loop 3).

---
 rtl/rc4_ksa_swap.sv | 154 +++++++++++++++
 tb/tb_rc4_ksa_swap.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_swap.sv
// RC4 key-scheduling swap pass (loop 2): walks i over the 256-entry S-memory,
// accumulates j = j + S[i] + key[i mod KEY_LEN] and swaps S[i] with S[j].
module rc4_ksa_swap #(
  parameter int RD_LAT  = 2,
  parameter int KEY_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  input  logic [7:0]           q_in,
  output logic [7:0]           address,
  output logic [7:0]           data,
  output logic                 wren,
  output logic                 done
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, DONE
  } state_t;

  state_t        state, state_n;
  logic [7:0]    i, i_n;
  logic [7:0]    j, j_n;
  logic [7:0]    si, si_n;
  logic [KW-1:0] kidx, kidx_n;
  logic [2:0]    wcnt, wcnt_n;
  logic [7:0]    address_n, data_n;
  logic          wren_n, done_n;
  logic          wait_end;
  logic [7:0]    key_byte;

  // key[0] sits in the most significant byte of secret_key
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_LEN; k++)
      if (kidx == KW'(k)) key_byte = secret_key[8*(KEY_LEN-1-k) +: 8];
  end

  assign wait_end = (wcnt == 3'(RD_LAT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      kidx    <= '0;
      wcnt    <= '0;
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      i       <= i_n;
      j       <= j_n;
      kidx    <= kidx_n;
      wcnt    <= wcnt_n;
      address <= address_n;
      data    <= data_n;
      wren    <= wren_n;
      done    <= done_n;
    end
    si <= si_n;
  end

  // Outputs are registered, so each branch loads the values seen in the next state.
  always_comb begin
    state_n   = state;
    i_n       = i;
    j_n       = j;
    si_n      = si;
    kidx_n    = kidx;
    wcnt_n    = wcnt;
    address_n = address;
    data_n    = data;
    wren_n    = 1'b0;
    done_n    = done;

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = RD_I;
          address_n = i;
          wcnt_n    = '0;
        end
      end

      RD_I: begin
        if (wait_end) begin
          state_n = CAP_I;
          wcnt_n  = '0;
        end else begin
          wcnt_n = wcnt + 3'd1;
        end
      end

      CAP_I: begin
        si_n      = q_in;
        j_n       = j + q_in + key_byte;
        address_n = j + q_in + key_byte;
        state_n   = RD_J;
      end

      RD_J: begin
        if (wait_end) begin
          state_n = CAP_J;
          wcnt_n  = '0;
        end else begin
          wcnt_n = wcnt + 3'd1;
        end
      end

      // The data register doubles as the sj latch for the WR_I write.
      CAP_J: begin
        state_n   = WR_I;
        address_n = i;
        data_n    = q_in;
        wren_n    = 1'b1;
      end

      WR_I: begin
        state_n   = WR_J;
        address_n = j;
        data_n    = si;
        wren_n    = 1'b1;
      end

      WR_J: begin
        if (i == 8'd255) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          i_n       = i + 8'd1;
          kidx_n    = (kidx == KW'(KEY_LEN - 1)) ? '0 : kidx + KW'(1);
          address_n = i + 8'd1;
          wcnt_n    = '0;
          state_n   = RD_I;
        end
      end

      DONE: begin
        done_n = 1'b1;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_swap.sv
// Bench for rc4_ksa_swap: two instances (RD_LAT=2 and RD_LAT=1) each driving a
// cycle-accurate S-memory model, compared against a software KSA model.
module tb_rc4_ksa_swap;

  logic        clk = 1'b0;
  logic        reset, start, ram_init;
  logic [23:0] secret_key;
  logic [7:0]  q2, addr2, data2;
  logic        wren2, done2;
  logic [7:0]  q1, addr1, data1;
  logic        wren1, done1;

  always #5 clk = ~clk;

  rc4_ksa_swap #(.RD_LAT(2), .KEY_LEN(3)) dut (
    .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
    .q_in(q2), .address(addr2), .data(data2), .wren(wren2), .done(done2));

  rc4_ksa_swap #(.RD_LAT(1), .KEY_LEN(3)) dut1 (
    .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
    .q_in(q1), .address(addr1), .data(data1), .wren(wren1), .done(done1));

  // Memory models: one arbiter register stage, then RAM (registered read for
  // the 2-cycle build, combinational read for the 1-cycle build).
  logic [7:0] mem2 [256];
  logic [7:0] mem1 [256];
  logic [7:0] a2_r, d2_r, a1_r, d1_r;
  logic       w2_r, w1_r;

  always @(posedge clk) begin
    a2_r <= addr2; d2_r <= data2; w2_r <= wren2;
    a1_r <= addr1; d1_r <= data1; w1_r <= wren1;
    q2   <= mem2[a2_r];
    if (ram_init) begin
      for (int k = 0; k < 256; k++) begin
        mem2[k] <= 8'(k);
        mem1[k] <= 8'(k);
      end
    end else begin
      if (w2_r === 1'b1) mem2[a2_r] <= d2_r;
      if (w1_r === 1'b1) mem1[a1_r] <= d1_r;
    end
  end
  assign q1 = mem1[a1_r];

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t wq2[$], wq1[$], exp_q[$];

  always @(negedge clk) begin
    if (wren2 === 1'b1) wq2.push_back({addr2, data2});
    if (wren1 === 1'b1) wq1.push_back({addr1, data1});
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference KSA on the model array ms, starting from j=0, logging the two
  // writes (S[i] <- S[j], S[j] <- S[i]) of every iteration.
  logic [7:0] ms [256];

  task automatic model_ksa(input logic [23:0] key, input int n);
    logic [7:0] jj, t;
    logic [7:0] kb [3];
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    jj = 8'h00;
    for (int ii = 0; ii < n; ii++) begin
      jj = jj + ms[ii] + kb[ii % 3];
      exp_q.push_back({8'(ii), ms[jj]});
      exp_q.push_back({jj, ms[ii]});
      t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
    end
  endtask

  task automatic model_init();
    for (int k = 0; k < 256; k++) ms[k] = 8'(k);
    exp_q.delete();
  endtask

  task automatic cmp_writes(input string name, input wr_t got[$], input wr_t exp[$]);
    int first = -1;
    for (int k = 0; k < exp.size() && k < got.size(); k++)
      if (got[k] !== exp[k] && first < 0) first = k;
    checks++;
    if (got.size() != exp.size() || first >= 0) begin
      failures++;
      $display("FAIL %s: %0d writes seen, %0d required, first differing write #%0d",
               name, got.size(), exp.size(), first);
    end
  endtask

  task automatic cmp_mem(input string name, input logic [7:0] m [256]);
    int first = -1;
    for (int k = 0; k < 256; k++)
      if (m[k] !== ms[k] && first < 0) first = k;
    checks++;
    if (first >= 0) begin
      failures++;
      $display("FAIL %s: S[%0d] is 0x%0h, required 0x%0h", name, first, m[first], ms[first]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; start = 1'b0; ram_init = 1'b1;
    @(negedge clk); reset = 1'b0; ram_init = 1'b0;
    wq2.delete(); wq1.delete();
  endtask

  // Raises start and counts cycles from the first RD_I cycle until done.
  task automatic run_pass(output int n2, output int n1);
    start = 1'b1;
    n2 = -1; n1 = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (done2 === 1'b1 && n2 < 0) n2 = n - 1;
      if (done1 === 1'b1 && n1 < 0) n1 = n - 1;
      if (n2 >= 0 && n1 >= 0) break;
    end
  endtask

  typedef struct {logic [23:0] key; int widx; logic [7:0] a; logic [7:0] d;} vec_t;
  vec_t        vt [12];
  logic [23:0] keys [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n2, n1, bad, got;
    reset = 1'b1; start = 1'b0; secret_key = '0; ram_init = 1'b1;

    vt[0]  = '{24'h000000, 0, 8'h00, 8'h00};
    vt[1]  = '{24'h000000, 1, 8'h00, 8'h00};
    vt[2]  = '{24'h000000, 4, 8'h02, 8'h03};
    vt[3]  = '{24'h000000, 5, 8'h03, 8'h02};
    vt[4]  = '{24'h0A0000, 0, 8'h00, 8'h0A};
    vt[5]  = '{24'h0A0000, 1, 8'h0A, 8'h00};
    vt[6]  = '{24'h000249, 0, 8'h00, 8'h00};
    vt[7]  = '{24'h000249, 1, 8'h00, 8'h00};
    vt[8]  = '{24'h000249, 2, 8'h01, 8'h03};
    vt[9]  = '{24'h000249, 3, 8'h03, 8'h01};
    vt[10] = '{24'h000249, 4, 8'h02, 8'h4E};
    vt[11] = '{24'h000249, 5, 8'h4E, 8'h02};

    keys[0] = 24'h000000; keys[1] = 24'h0A0000; keys[2] = 24'h000249;
    for (int r = 3; r < 6; r++) keys[r] = 24'($urandom);

    repeat (2) @(negedge clk);
    check("reset_outputs", {addr2, data2, 6'b0, wren2, done2}, 32'h0);
    check("reset_ij", {dut.i, dut.j}, 32'h0);

    for (int k = 0; k < 6; k++) begin
      secret_key = keys[k];
      do_reset();
      run_pass(n2, n1);
      check($sformatf("done_latency_rdlat2_key%06h", keys[k]), n2, 2048);
      check($sformatf("done_latency_rdlat1_key%06h", keys[k]), n1, 1536);
      if (k == 0) begin
        bad = 0;
        for (int c = 0; c < 100; c++) begin
          start = 1'($urandom);
          @(negedge clk);
          if (done2 !== 1'b1 || done1 !== 1'b1 || wren2 !== 1'b0 || wren1 !== 1'b0) bad++;
        end
        check("done_sticky_cycles_bad", bad, 0);
        start = 1'b1;
      end else begin
        repeat (3) @(negedge clk);
      end
      check($sformatf("wren_pulses_rdlat2_key%06h", keys[k]), wq2.size(), 512);
      model_init();
      model_ksa(keys[k], 256);
      cmp_writes($sformatf("writes_rdlat2_key%06h", keys[k]), wq2, exp_q);
      cmp_writes($sformatf("writes_rdlat1_key%06h", keys[k]), wq1, exp_q);
      cmp_mem($sformatf("final_s_rdlat2_key%06h", keys[k]), mem2);
      cmp_mem($sformatf("final_s_rdlat1_key%06h", keys[k]), mem1);
      for (int v = 0; v < 12; v++) begin
        if (vt[v].key == keys[k]) begin
          got = (wq2.size() > vt[v].widx) ? int'({wq2[vt[v].widx].a, wq2[vt[v].widx].d}) : -1;
          check($sformatf("write%0d_key%06h", vt[v].widx, keys[k]), got, {16'h0, vt[v].a, vt[v].d});
        end
      end
    end

    // Reset in the first RD_I cycle of iteration 100, start held high.
    secret_key = 24'h000249;
    do_reset();
    start = 1'b1;
    got = 0;
    for (int c = 0; c < 3000 && wq2.size() < 200; c++) @(negedge clk);
    check("iter100_reached", wq2.size(), 200);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_outputs", {addr2, data2, 6'b0, wren2, done2}, 32'h0);
    check("midreset_outputs_rdlat1", {addr1, data1, 6'b0, wren1, done1}, 32'h0);
    check("midreset_ij", {dut.i, dut.j}, 32'h0);
    wq2.delete(); wq1.delete();
    run_pass(n2, n1);
    check("restart_done_latency_rdlat2", n2, 2048);
    check("restart_done_latency_rdlat1", n1, 1536);
    repeat (3) @(negedge clk);
    model_init();
    model_ksa(24'h000249, 100);
    exp_q.delete();
    model_ksa(24'h000249, 256);
    cmp_writes("restart_writes_rdlat2", wq2, exp_q);
    cmp_mem("restart_final_s_rdlat2", mem2);

    // start held low: nothing happens; then the first addresses of a pass.
    secret_key = 24'h0A0000;
    do_reset();
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (wren2 !== 1'b0 || wren1 !== 1'b0 || addr2 !== 8'h00 || addr1 !== 8'h00 ||
          done2 !== 1'b0 || done1 !== 1'b0) bad++;
    end
    check("idle_cycles_bad", bad, 0);
    check("idle_writes", wq2.size() + wq1.size(), 0);
    start = 1'b1;
    @(negedge clk);
    check("first_rd_i_addr", {addr2, 7'b0, wren2}, {8'h00, 8'h00});
    @(negedge clk);
    @(negedge clk);
    check("first_rd_j_addr_rdlat1", addr1, 8'h0A);
    @(negedge clk);
    check("first_rd_j_addr_rdlat2", addr2, 8'h0A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
